prio_arbiter_pipe: RTL and testbench
====================================

PRIO_ARBITER_PIPE -- requirements
Module: prio_arbiter_pipe

Interface
REQ-001 Parameter N_CH, default 8: number of source channels, legal range 2..32.
REQ-002 Parameter DATA_W, default 8: payload width per channel.
REQ-003 Parameter PRIO_W, default 8: priority field width; a larger value is more urgent.
REQ-004 Parameter AGE_MAX, default 15: wait-cycle count at which a channel becomes starved; IDX_W = clog2(N_CH).
REQ-005 Port clk, input, 1: single clock, rising edge.
REQ-006 Port reset, input, 1: asynchronous active-high reset.
REQ-007 Port mode_i, input, 1: tie-break mode; 0 = fixed lowest-index, 1 = round-robin.
REQ-008 Port valid_i, input, N_CH: per-channel request.
REQ-009 Port data_i, input, N_CH x DATA_W: per-channel payload.
REQ-010 Port priority_i, input, N_CH x PRIO_W: per-channel priority.
REQ-011 Port ready_i, output, N_CH: per-channel grant/accept, at most one bit set.
REQ-012 Port valid_o, output, 1: output slot holds a winner.
REQ-013 Port data_o, output, DATA_W: winner payload.
REQ-014 Port chan_o, output, IDX_W: winner channel index.
REQ-015 Port ready_o, input, 1: downstream accept.

Function
REQ-016 can_accept = !valid_o || ready_o; ready_i SHALL be all-zero whenever can_accept=0 or valid_i=0.
REQ-017 When can_accept=1 and any valid_i is set, exactly one ready_i bit SHALL assert combinationally, for the winner.
REQ-018 Winner: among starved valid channels if any exist, otherwise among all valid channels; choose maximum priority_i; resolve ties per REQ-019.
REQ-019 Tie-break: mode_i=0 lowest index; mode_i=1 first tied index at or after rr_ptr, scanning upward and wrapping N_CH-1 -> 0.
REQ-020 rr_ptr SHALL update to (winner+1) mod N_CH on every grant, in both modes; it holds otherwise.
REQ-021 A grant on channel k at cycle t SHALL produce valid_o=1, data_o=data_i[k], chan_o=k at t+1; latency is 1 cycle and throughput is 1 per cycle while ready_o=1.
REQ-022 While valid_o=1 and ready_o=0, valid_o, data_o and chan_o SHALL hold stable.
REQ-023 On valid_o && ready_o with no grant that cycle, valid_o SHALL drop next cycle; with a grant, the slot SHALL reload with no bubble.
REQ-024 Age counter per channel: clear on grant or valid_i=0; otherwise +1 each cycle the channel is valid and not granted; saturate at AGE_MAX; starved means age == AGE_MAX.
REQ-025 Age counters SHALL advance during output stalls (can_accept=0).
REQ-026 A change on mode_i SHALL take effect in the same cycle's arbitration; rr_ptr and age counters are unaffected by the change.
REQ-027 Priority comparison is unsigned PRIO_W-bit; no +1 offset; a priority of 0 with valid=1 still wins over invalid channels.
REQ-028 Sources may drop valid_i without a handshake; the arbiter SHALL make no assumption about valid persistence.

Reset
REQ-029 During reset: valid_o=0, data_o=0, chan_o=0, rr_ptr=0, all age counters 0, ready_i=0.
REQ-030 Reset asserted mid-transfer SHALL discard the held output word; the first grant is possible the cycle after deassertion.

Structure
REQ-031 Shared package arb_pkg SHALL hold the default parameters, the IDX_W computation and the mode encoding constants (MODE_FIXED=0, MODE_RR=1).
REQ-032 Per-channel aging SHALL be a sub-module prio_arb_age_ctr, instantiated N_CH times; selection and the output register stay in the top module.

Verification
REQ-033 Verification scenario: N_CH=8, valid on ch2 (prio 5) and ch6 (prio 9), ready_o=1 -> ready_i=0x40; next cycle chan_o=6 and data_o=data_i[6].
REQ-034 Verification scenario: all 8 channels valid, prio 3, mode_i=1, ready_o=1, 8 cycles -> grant order 0,1,...,7, then 0 again.
REQ-035 Verification scenario: identical to the previous one with mode_i=0 -> ch0 granted every cycle until ch1 reaches age 15, then ch1 is granted (starvation escape).
REQ-036 Verification scenario: winner ch4 with ready_o=0 for 5 cycles -> valid_o, data_o and chan_o stable; ready_i=0 throughout; on ready_o=1 the next winner loads the cycle after with no bubble.
REQ-037 Verification scenario: reset asserted while valid_o=1 -> valid_o=0 and ready_i=0 immediately (asynchronous); after release, first grant comes one cycle later with rr_ptr=0.
REQ-038 Verification scenario: concurrently, a random stress run (10k cycles, N_CH=4/8/16) SHALL be checked for: ready_i one-hot-or-zero, the winner matching a reference model, and every valid_i held for AGE_MAX+N_CH cycles being granted.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared constants for the priority arbiter: default parameters, tie-break
// mode encodings and the index/age width helpers.
package arb_pkg;

    localparam int DEF_N_CH    = 8;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_PRIO_W  = 8;
    localparam int DEF_AGE_MAX = 15;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic int calc_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int calc_age_w(input int age_max);
        return (age_max > 0) ? $clog2(age_max + 1) : 1;
    endfunction

endpackage

// File: rtl/prio_arb_age_ctr.sv
// Per-channel wait counter: counts cycles a request has waited without a grant
// and flags the channel as starved once the count saturates.
module prio_arb_age_ctr
    import arb_pkg::*;
#(
    parameter int AGE_MAX = DEF_AGE_MAX,
    localparam int AGE_W  = calc_age_w(AGE_MAX)
) (
    input  logic clk,
    input  logic reset,
    input  logic valid,
    input  logic grant,
    output logic starved
);

    localparam logic [AGE_W-1:0] AGE_SAT = AGE_W'(AGE_MAX);

    logic [AGE_W-1:0] age_r;

    // Age register: cleared by a grant or a dropped request, saturating otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            age_r <= '0;
        end else if (grant || !valid) begin
            age_r <= '0;
        end else if (age_r != AGE_SAT) begin
            age_r <= age_r + 1'b1;
        end else begin
            age_r <= age_r;
        end
    end

    assign starved = (age_r == AGE_SAT);

endmodule

// File: rtl/prio_arbiter_pipe.sv
// N-channel priority arbiter with starvation escape, fixed or round-robin
// tie-break, and a single registered output slot with valid/ready handshake.
module prio_arbiter_pipe
    import arb_pkg::*;
#(
    parameter int N_CH    = DEF_N_CH,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int PRIO_W  = DEF_PRIO_W,
    parameter int AGE_MAX = DEF_AGE_MAX,
    localparam int IDX_W  = calc_idx_w(N_CH)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           mode_i,
    input  logic [N_CH-1:0]                valid_i,
    input  logic [N_CH-1:0][DATA_W-1:0]    data_i,
    input  logic [N_CH-1:0][PRIO_W-1:0]    priority_i,
    output logic [N_CH-1:0]                ready_i,
    output logic                           valid_o,
    output logic [DATA_W-1:0]              data_o,
    output logic [IDX_W-1:0]               chan_o,
    input  logic                           ready_o
);

    localparam logic [N_CH-1:0] ONE_HOT0 = {{(N_CH-1){1'b0}}, 1'b1};

    logic                valid_o_r;
    logic [DATA_W-1:0]   data_o_r;
    logic [IDX_W-1:0]    chan_o_r;
    logic [IDX_W-1:0]    rr_ptr_r;

    logic [N_CH-1:0]     starved_s;
    logic [N_CH-1:0]     starved_valid_s;
    logic [N_CH-1:0]     cand_s;
    logic [N_CH-1:0]     tie_s;
    logic [PRIO_W-1:0]   max_prio_s;
    logic [IDX_W-1:0]    win_s;
    logic                can_accept_s;
    logic                grant_s;
    logic [N_CH-1:0]     grant_vec_s;

    for (genvar g = 0; g < N_CH; g++) begin : g_age
        prio_arb_age_ctr #(
            .AGE_MAX (AGE_MAX)
        ) u_age (
            .clk     (clk),
            .reset   (reset),
            .valid   (valid_i[g]),
            .grant   (grant_vec_s[g]),
            .starved (starved_s[g])
        );
    end

    // Candidate set and the highest priority within it, then every tied candidate.
    always_comb begin
        starved_valid_s = valid_i & starved_s;
        if (|starved_valid_s) begin
            cand_s = starved_valid_s;
        end else begin
            cand_s = valid_i;
        end
        max_prio_s = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (cand_s[i] && (priority_i[i] > max_prio_s)) begin
                max_prio_s = priority_i[i];
            end else begin
                max_prio_s = max_prio_s;
            end
        end
        tie_s = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (cand_s[i] && (priority_i[i] == max_prio_s)) begin
                tie_s[i] = 1'b1;
            end else begin
                tie_s[i] = 1'b0;
            end
        end
    end

    // Tie-break among equal-priority candidates: lowest index or scan from rr_ptr.
    always_comb begin
        logic found;
        int   idx;
        win_s = '0;
        found = 1'b0;
        idx   = 0;
        if (mode_i == MODE_RR) begin
            for (int i = 0; i < N_CH; i++) begin
                idx = int'(rr_ptr_r) + i;
                if (idx >= N_CH) begin
                    idx = idx - N_CH;
                end else begin
                    idx = idx;
                end
                if (!found && tie_s[IDX_W'(idx)]) begin
                    found = 1'b1;
                    win_s = IDX_W'(idx);
                end else begin
                    found = found;
                end
            end
        end else begin
            // Downward scan so the lowest tied index is the last one written.
            for (int i = N_CH - 1; i >= 0; i--) begin
                if (tie_s[i]) begin
                    win_s = IDX_W'(i);
                end else begin
                    win_s = win_s;
                end
            end
        end
    end

    // Grant decision; gated by reset so no request is accepted while it is held.
    always_comb begin
        can_accept_s = !valid_o_r || ready_o;
        grant_s      = can_accept_s && (|valid_i) && !reset;
        if (grant_s) begin
            grant_vec_s = ONE_HOT0 << win_s;
        end else begin
            grant_vec_s = '0;
        end
    end

    // Output slot and round-robin pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_o_r <= 1'b0;
            data_o_r  <= '0;
            chan_o_r  <= '0;
            rr_ptr_r  <= '0;
        end else if (grant_s) begin
            valid_o_r <= 1'b1;
            data_o_r  <= data_i[win_s];
            chan_o_r  <= win_s;
            rr_ptr_r  <= (win_s == IDX_W'(N_CH - 1)) ? '0 : win_s + 1'b1;
        end else if (ready_o) begin
            valid_o_r <= 1'b0;
            data_o_r  <= data_o_r;
            chan_o_r  <= chan_o_r;
            rr_ptr_r  <= rr_ptr_r;
        end else begin
            valid_o_r <= valid_o_r;
            data_o_r  <= data_o_r;
            chan_o_r  <= chan_o_r;
            rr_ptr_r  <= rr_ptr_r;
        end
    end

    assign ready_i = grant_vec_s;
    assign valid_o = valid_o_r;
    assign data_o  = data_o_r;
    assign chan_o  = chan_o_r;

endmodule

// File: tb/tb_prio_arbiter_pipe.sv
// Directed self-checking bench for prio_arbiter_pipe (N_CH=8).
module tb_prio_arbiter_pipe;

    localparam int N  = 8;
    localparam int DW = 8;
    localparam int PW = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 mode_i;
    logic [N-1:0]         valid_i;
    logic [N-1:0][DW-1:0] data_i;
    logic [N-1:0][PW-1:0] priority_i;
    logic [N-1:0]         ready_i;
    logic                 valid_o;
    logic [DW-1:0]        data_o;
    logic [2:0]           chan_o;
    logic                 ready_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    prio_arbiter_pipe #(
        .N_CH    (N),
        .DATA_W  (DW),
        .PRIO_W  (PW),
        .AGE_MAX (15)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mode_i     (mode_i),
        .valid_i    (valid_i),
        .data_i     (data_i),
        .priority_i (priority_i),
        .ready_i    (ready_i),
        .valid_o    (valid_o),
        .data_o     (data_o),
        .chan_o     (chan_o),
        .ready_o    (ready_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all_prio(input logic [PW-1:0] p);
        for (int k = 0; k < N; k++) priority_i[k] = p;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        valid_i = '0;
        ready_o = 1'b1;
        mode_i  = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        valid_i = 8'hFF;
        ready_o = 1'b1;
        set_all_prio(8'd3);
        step();
        step();
        total++; if (ready_i !== 8'h00) begin bad++; $display("FAIL reset_ready_i got=%h exp=00", ready_i); end
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid_o got=%b exp=0", valid_o); end
        total++; if (data_o !== 8'h00) begin bad++; $display("FAIL reset_data_o got=%h exp=00", data_o); end
        total++; if (chan_o !== 3'd0) begin bad++; $display("FAIL reset_chan_o got=%0d exp=0", chan_o); end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        set_all_prio(8'd0);
        valid_i       = 8'b0100_0100;
        priority_i[2] = 8'd5;
        priority_i[6] = 8'd9;
        #1;
        total++; if (ready_i !== 8'h40) begin bad++; $display("FAIL basic_grant got=%h exp=40", ready_i); end
        step();
        total++; if ({valid_o, chan_o, data_o} !== {1'b1, 3'd6, 8'hA6}) begin
            bad++; $display("FAIL basic_out got=%b/%0d/%h exp=1/6/a6", valid_o, chan_o, data_o);
        end
        valid_i = '0;
        #1;
        total++; if (ready_i !== 8'h00) begin bad++; $display("FAIL basic_idle_ready got=%h exp=00", ready_i); end
        step();
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL basic_drop got=%b exp=0", valid_o); end
    endtask

    task automatic test_round_robin();
        int e;
        do_reset();
        mode_i  = 1'b1;
        valid_i = 8'hFF;
        set_all_prio(8'd3);
        for (int k = 0; k < 9; k++) begin
            e = k % 8;
            #1;
            total++; if (ready_i !== (8'h01 << e)) begin
                bad++; $display("FAIL rr_grant[%0d] got=%h exp=%h", k, ready_i, 8'h01 << e);
            end
            step();
            total++; if ({valid_o, chan_o} !== {1'b1, 3'(e)}) begin
                bad++; $display("FAIL rr_chan[%0d] got=%b/%0d exp=1/%0d", k, valid_o, chan_o, e);
            end
        end
    endtask

    task automatic test_starvation();
        int e;
        do_reset();
        mode_i  = 1'b0;
        valid_i = 8'hFF;
        set_all_prio(8'd3);
        for (int c = 0; c < 17; c++) begin
            e = (c < 15) ? 0 : ((c == 15) ? 1 : 2);
            #1;
            total++; if (ready_i !== (8'h01 << e)) begin
                bad++; $display("FAIL starve_grant[%0d] got=%h exp=%h", c, ready_i, 8'h01 << e);
            end
            step();
            total++; if (chan_o !== 3'(e)) begin
                bad++; $display("FAIL starve_chan[%0d] got=%0d exp=%0d", c, chan_o, e);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        mode_i        = 1'b0;
        set_all_prio(8'd0);
        valid_i       = 8'h10;
        priority_i[4] = 8'd7;
        data_i[4]     = 8'h44;
        #1;
        total++; if (ready_i !== 8'h10) begin bad++; $display("FAIL stall_first got=%h exp=10", ready_i); end
        step();
        total++; if ({valid_o, chan_o, data_o} !== {1'b1, 3'd4, 8'h44}) begin
            bad++; $display("FAIL stall_load got=%b/%0d/%h exp=1/4/44", valid_o, chan_o, data_o);
        end
        ready_o   = 1'b0;
        data_i[4] = 8'h55;
        // Fifteen stalled cycles bring ch4 to saturation while it waits.
        for (int s = 0; s < 15; s++) begin
            if (s == 14) begin
                valid_i[1]    = 1'b1;
                priority_i[1] = 8'd9;
            end
            #1;
            total++; if (ready_i !== 8'h00) begin bad++; $display("FAIL stall_ready[%0d] got=%h exp=00", s, ready_i); end
            total++; if ({valid_o, chan_o, data_o} !== {1'b1, 3'd4, 8'h44}) begin
                bad++; $display("FAIL stall_hold[%0d] got=%b/%0d/%h exp=1/4/44", s, valid_o, chan_o, data_o);
            end
            step();
        end
        ready_o = 1'b1;
        #1;
        total++; if (ready_i !== 8'h10) begin bad++; $display("FAIL stall_starved_win got=%h exp=10", ready_i); end
        step();
        total++; if ({valid_o, chan_o, data_o} !== {1'b1, 3'd4, 8'h55}) begin
            bad++; $display("FAIL stall_reload got=%b/%0d/%h exp=1/4/55", valid_o, chan_o, data_o);
        end
        #1;
        total++; if (ready_i !== 8'h02) begin bad++; $display("FAIL stall_next got=%h exp=02", ready_i); end
        step();
        total++; if ({valid_o, chan_o, data_o} !== {1'b1, 3'd1, 8'hA1}) begin
            bad++; $display("FAIL stall_next_out got=%b/%0d/%h exp=1/1/a1", valid_o, chan_o, data_o);
        end
    endtask

    task automatic test_mode_switch();
        do_reset();
        mode_i  = 1'b1;
        valid_i = 8'hFF;
        set_all_prio(8'd3);
        #1;
        total++; if (ready_i !== 8'h01) begin bad++; $display("FAIL mode_rr0 got=%h exp=01", ready_i); end
        step();
        mode_i = 1'b0;
        #1;
        total++; if (ready_i !== 8'h01) begin bad++; $display("FAIL mode_fixed got=%h exp=01", ready_i); end
        step();
        mode_i = 1'b1;
        #1;
        total++; if (ready_i !== 8'h02) begin bad++; $display("FAIL mode_rr1 got=%h exp=02", ready_i); end
        step();
        total++; if (chan_o !== 3'd1) begin bad++; $display("FAIL mode_chan got=%0d exp=1", chan_o); end
    endtask

    task automatic test_priority_edges();
        do_reset();
        set_all_prio(8'd0);
        valid_i = 8'h20;
        #1;
        total++; if (ready_i !== 8'h20) begin bad++; $display("FAIL prio_zero got=%h exp=20", ready_i); end
        priority_i[3] = 8'hFF;
        priority_i[5] = 8'h7F;
        valid_i       = 8'h28;
        #1;
        total++; if (ready_i !== 8'h08) begin bad++; $display("FAIL prio_unsigned got=%h exp=08", ready_i); end
        priority_i[3] = 8'd0;
        priority_i[5] = 8'd1;
        #1;
        total++; if (ready_i !== 8'h20) begin bad++; $display("FAIL prio_small got=%h exp=20", ready_i); end
        step();
        total++; if ({chan_o, data_o} !== {3'd5, 8'hA5}) begin
            bad++; $display("FAIL prio_out got=%0d/%h exp=5/a5", chan_o, data_o);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        mode_i  = 1'b1;
        valid_i = 8'hFF;
        set_all_prio(8'd3);
        step();
        step();
        ready_o = 1'b0;
        step();
        total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL rmid_pre got=%b exp=1", valid_o); end
        #2;
        reset = 1'b1;
        #1;
        total++; if ({valid_o, chan_o, data_o} !== {1'b0, 3'd0, 8'h00}) begin
            bad++; $display("FAIL rmid_async got=%b/%0d/%h exp=0/0/00", valid_o, chan_o, data_o);
        end
        total++; if (ready_i !== 8'h00) begin bad++; $display("FAIL rmid_ready got=%h exp=00", ready_i); end
        step();
        reset = 1'b0;
        #1;
        total++; if (ready_i !== 8'h01) begin bad++; $display("FAIL rmid_first got=%h exp=01", ready_i); end
        step();
        total++; if ({valid_o, chan_o} !== {1'b1, 3'd0}) begin
            bad++; $display("FAIL rmid_out got=%b/%0d exp=1/0", valid_o, chan_o);
        end
    endtask

    initial begin
        reset      = 1'b1;
        mode_i     = 1'b0;
        ready_o    = 1'b1;
        valid_i    = '0;
        priority_i = '0;
        for (int k = 0; k < N; k++) data_i[k] = 8'hA0 + 8'(k);
        test_reset();
        test_basic();
        test_round_robin();
        test_starvation();
        test_stall();
        test_mode_switch();
        test_priority_edges();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
